activation_pipeline: RTL and testbench

//  Multi-lane, pipelined, mode-selectable activation unit for the generator/discriminator datapath.

---
 rtl/act_pkg.sv | 59 +++++
 rtl/pwl_sigmoid_lane.sv | 39 +++
 rtl/activation_pipeline.sv | 132 +++++++++++++
 tb/tb_activation_pipeline.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_pkg.sv
// Shared definitions for the activation pipeline: mode encodings, PWL sigmoid
// constants as functions of the fraction width, and the SiLU round/saturate step.
package act_pkg;

  typedef enum logic [1:0] {
    ACT_BYPASS  = 2'd0,
    ACT_RELU    = 2'd1,
    ACT_SIGMOID = 2'd2,
    ACT_SILU    = 2'd3
  } act_mode_e;

  // 1.0 in Q.frac
  function automatic int sig_one(input int frac);
    return 1 << frac;
  endfunction

  // Breakpoints on |x|: 5.0, 2.375 (19/8), 1.0
  function automatic int brk_hi(input int frac);
    return 5 << frac;
  endfunction

  function automatic int brk_mid(input int frac);
    return 19 << (frac - 3);
  endfunction

  function automatic int brk_lo(input int frac);
    return 1 << frac;
  endfunction

  // Segment offsets: 0.84375 (27/32), 0.625 (5/8), 0.5
  function automatic int off_hi(input int frac);
    return 27 << (frac - 5);
  endfunction

  function automatic int off_mid(input int frac);
    return 5 << (frac - 3);
  endfunction

  function automatic int off_lo(input int frac);
    return 1 << (frac - 1);
  endfunction

  // Round half up (toward +inf), drop frac bits, clamp to a signed dw-bit range
  function automatic longint round_sat(input longint prod, input int frac, input int dw);
    longint r;
    longint hi;
    longint lo;
    r  = (prod + (longint'(1) <<< (frac - 1))) >>> frac;
    hi = (longint'(1) <<< (dw - 1)) - 1;
    lo = -(longint'(1) <<< (dw - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/pwl_sigmoid_lane.sv
// Combinational single-lane piecewise-linear sigmoid. Takes |x| and the sign of x,
// returns sigmoid(x) as an unsigned Q value in [0, 1.0].
module pwl_sigmoid_lane
  import act_pkg::*;
#(
  parameter int unsigned DW   = 16,
  parameter int unsigned FRAC = 12
) (
  input  logic          neg,
  input  logic [DW-1:0] a,
  output logic [DW-1:0] y
);

  localparam logic [DW-1:0] One    = DW'(sig_one(FRAC));
  localparam logic [DW-1:0] BrkHi  = DW'(brk_hi(FRAC));
  localparam logic [DW-1:0] BrkMid = DW'(brk_mid(FRAC));
  localparam logic [DW-1:0] BrkLo  = DW'(brk_lo(FRAC));
  localparam logic [DW-1:0] OffHi  = DW'(off_hi(FRAC));
  localparam logic [DW-1:0] OffMid = DW'(off_mid(FRAC));
  localparam logic [DW-1:0] OffLo  = DW'(off_lo(FRAC));

  logic [DW-1:0] y_pos;

  // Segment select on |x|, then mirror about 0.5 for negative inputs
  always_comb begin
    y_pos = One;
    if (a >= BrkHi) begin
      y_pos = One;
    end else if (a >= BrkMid) begin
      y_pos = (a >> 5) + OffHi;
    end else if (a >= BrkLo) begin
      y_pos = (a >> 3) + OffMid;
    end else begin
      y_pos = (a >> 2) + OffLo;
    end
    y = neg ? (One - y_pos) : y_pos;
  end

endmodule

// File: rtl/activation_pipeline.sv
// Three-stage, multi-lane activation unit with valid/ready streaming.
// S1: capture beat and |x|; S2: PWL sigmoid; S3: mode mux / SiLU multiply (output reg).
module activation_pipeline
  import act_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned FRAC  = 12,
  parameter int unsigned LANES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_mode,
  input  logic [LANES*DW-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*DW-1:0] out_data
);

  typedef logic [LANES-1:0][DW-1:0] lanes_t;

  logic      v1, v2, v3;
  logic      load1, load2, load3;
  act_mode_e mode1, mode2;
  lanes_t    in_lanes, abs_c, x1, a1, sig_c, x2, sig2, y3_d, out_q;

  // Bubble-collapsing advance: a stage loads when empty or when its successor loads
  assign load3    = !v3 || out_ready;
  assign load2    = !v2 || load3;
  assign load1    = !v1 || load2;
  assign in_ready = load1;

  assign in_lanes  = in_data;
  assign out_valid = v3;
  assign out_data  = out_q;

  // Per-lane |x|; the most negative value clamps to the largest positive
  always_comb begin
    abs_c = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (!in_lanes[i][DW-1]) begin
        abs_c[i] = in_lanes[i];
      end else if (in_lanes[i] == {1'b1, {(DW-1){1'b0}}}) begin
        abs_c[i] = {1'b0, {(DW-1){1'b1}}};
      end else begin
        abs_c[i] = -in_lanes[i];
      end
    end
  end

  // S1 register: beat data, mode and |x|
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      mode1 <= ACT_BYPASS;
      x1    <= '0;
      a1    <= '0;
    end else if (load1) begin
      v1 <= in_valid;
      if (in_valid) begin
        mode1 <= act_mode_e'(in_mode);
        x1    <= in_lanes;
        a1    <= abs_c;
      end
    end
  end

  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    pwl_sigmoid_lane #(
      .DW  (DW),
      .FRAC(FRAC)
    ) u_pwl (
      .neg(x1[g][DW-1]),
      .a  (a1[g]),
      .y  (sig_c[g])
    );
  end

  // S2 register: sigmoid per lane, with x and mode carried along
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2    <= 1'b0;
      mode2 <= ACT_BYPASS;
      x2    <= '0;
      sig2  <= '0;
    end else if (load2) begin
      v2 <= v1;
      if (v1) begin
        mode2 <= mode1;
        x2    <= x1;
        sig2  <= sig_c;
      end
    end
  end

  logic signed [2*DW-1:0] xe, se, prod;

  // S3 next value: mode mux; SiLU is a full-width signed product, rounded and clamped
  always_comb begin
    y3_d = '0;
    xe   = '0;
    se   = '0;
    prod = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      xe   = {{DW{x2[i][DW-1]}}, x2[i]};
      se   = {{DW{1'b0}}, sig2[i]};
      prod = xe * se;
      unique case (mode2)
        ACT_BYPASS:  y3_d[i] = x2[i];
        ACT_RELU:    y3_d[i] = x2[i][DW-1] ? '0 : x2[i];
        ACT_SIGMOID: y3_d[i] = sig2[i];
        ACT_SILU:    y3_d[i] = DW'(round_sat(longint'(prod), FRAC, DW));
        default:     y3_d[i] = x2[i];
      endcase
    end
  end

  // S3 output register; data only changes when a new beat moves in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3    <= 1'b0;
      out_q <= '0;
    end else if (load3) begin
      v3 <= v2;
      if (v2) begin
        out_q <= y3_d;
      end
    end
  end

endmodule

// File: tb/tb_activation_pipeline.sv
// Directed and randomized checks of the activation pipeline (Q4.12, 4 lanes).
module tb_activation_pipeline;

  localparam int NRand = 10000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mode;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  activation_pipeline #(
    .DW   (16),
    .FRAC (12),
    .LANES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    logic [63:0] r;
    r = {d[15:0], c[15:0], b[15:0], a[15:0]};
    return r;
  endfunction

  // Reference activation on an integer Q4.12 value
  function automatic int ref_act(input int mode, input int x);
    int a, s, p, r;
    a = (x < 0) ? -x : x;
    if (a > 32767) a = 32767;
    if (a >= 20480)     s = 4096;
    else if (a >= 9728) s = a / 32 + 3456;
    else if (a >= 4096) s = a / 8 + 2560;
    else                s = a / 4 + 2048;
    if (x < 0) s = 4096 - s;
    case (mode)
      0:       r = x;
      1:       r = (x < 0) ? 0 : x;
      2:       r = s;
      default: begin
        p = x * s + 2048;
        r = p >>> 12;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
      end
    endcase
    return r;
  endfunction

  function automatic logic [63:0] ref_beat(input logic [1:0] m, input logic [63:0] d);
    logic [63:0] r;
    logic [15:0] lv;
    int x, y;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      lv = d[i*16 +: 16];
      x  = int'($signed(lv));
      y  = ref_act(int'(m), x);
      r[i*16 +: 16] = y[15:0];
    end
    return r;
  endfunction

  function automatic logic [63:0] b2b_data(input int k);
    return pack4(k * 2731 - 20000, 15000 - k * 1999, k * k * 100 - 3000,
                 (k % 2 == 1) ? -32768 : 32767);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for a single cycle (caller checks in_ready beforehand)
  task automatic push_beat(input logic [1:0] m, input logic [63:0] d);
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if (out_data !== 64'h0) begin
      n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_silu();
    logic [63:0] exp_v;
    exp_v = pack4(3072, -1024, 0, 20480);
    out_ready = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL silu_in_ready: got %b expected 1", in_ready);
    end
    push_beat(2'd3, pack4(4096, -4096, 0, 20480));
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL silu_lat1: out_valid got %b expected 0", out_valid);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL silu_lat2: out_valid got %b expected 0", out_valid);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL silu_lat3: out_valid got %b expected 1", out_valid);
    end
    n_checks++;
    if (out_data !== exp_v) begin
      n_fail++; $display("FAIL silu_data: got %h expected %h", out_data, exp_v);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL silu_single: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_sigmoid_relu();
    logic [63:0] exp_s, exp_r;
    exp_s = pack4(2048, 3072, 0, 4096);
    exp_r = pack4(0, 0, 0, 32767);
    out_ready = 1'b1;
    push_beat(2'd2, pack4(0, 4096, -32768, 20480));
    push_beat(2'd1, pack4(-32768, -1, 0, 32767));
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== exp_s) begin
      n_fail++;
      $display("FAIL sigmoid_data: got v=%b %h expected v=1 %h", out_valid, out_data, exp_s);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== exp_r) begin
      n_fail++;
      $display("FAIL relu_data: got v=%b %h expected v=1 %h", out_valid, out_data, exp_r);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL sigrelu_drain: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_saturation();
    logic [63:0] exp_b, exp_s;
    exp_b = pack4(-32768, 32767, 1, -1);
    exp_s = pack4(32767, 0, 0, -1);
    out_ready = 1'b1;
    push_beat(2'd0, pack4(-32768, 32767, 1, -1));
    push_beat(2'd3, pack4(32767, -32768, -1, -3));
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== exp_b) begin
      n_fail++;
      $display("FAIL bypass_extremes: got v=%b %h expected v=1 %h", out_valid, out_data, exp_b);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== exp_s) begin
      n_fail++;
      $display("FAIL silu_sat_round: got v=%b %h expected v=1 %h", out_valid, out_data, exp_s);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int sent, recv, c;
    logic stall;
    logic [63:0] last_data, exp_v;
    sent = 0; recv = 0; c = 0; stall = 1'b0; last_data = '0;
    while (recv < 16 && c < 200) begin
      in_valid  = (sent < 16);
      in_mode   = 2'(sent % 4);
      in_data   = b2b_data(sent);
      out_ready = !(c >= 5 && c <= 9);
      @(negedge clk);
      if (c == 7) begin
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++; $display("FAIL b2b_full_in_ready: got %b expected 0", in_ready);
        end
      end
      if (stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== last_data) begin
          n_fail++;
          $display("FAIL b2b_stall_hold: got v=%b %h expected v=1 %h", out_valid, out_data,
                   last_data);
        end
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        exp_v = ref_beat(2'(recv % 4), b2b_data(recv));
        n_checks++;
        if (out_data !== exp_v) begin
          n_fail++; $display("FAIL b2b_beat%0d: got %h expected %h", recv, out_data, exp_v);
        end
        recv++;
      end
      stall     = out_valid && !out_ready;
      last_data = out_data;
      @(posedge clk);
      #1;
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (recv != 16) begin
      n_fail++; $display("FAIL b2b_count: got %0d beats expected 16", recv);
    end
    step();
    step();
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_no_dup: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_random();
    logic [63:0] q[$];
    logic [63:0] exp_v, last_data;
    int sent, recv, cyc, nprint;
    logic acc, stall;
    sent = 0; recv = 0; cyc = 0; nprint = 0;
    acc = 1'b0; stall = 1'b0; last_data = '0;
    in_valid = 1'b0;
    while (recv < NRand && cyc < 60000) begin
      if (!in_valid || acc) begin
        if (sent < NRand && $urandom_range(0, 1) == 1) begin
          in_valid = 1'b1;
          in_mode  = 2'($urandom_range(0, 3));
          in_data  = {$urandom, $urandom};
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== last_data) begin
          n_fail++;
          if (nprint < 10) $display("FAIL rand_stall_hold: got v=%b %h expected v=1 %h",
                                    out_valid, out_data, last_data);
          nprint++;
        end
      end
      acc = in_valid && in_ready;
      if (acc) begin
        q.push_back(ref_beat(in_mode, in_data));
        sent++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          if (nprint < 10) $display("FAIL rand_extra_beat: got %h expected none", out_data);
          nprint++;
        end else begin
          exp_v = q.pop_front();
          if (out_data !== exp_v) begin
            n_fail++;
            if (nprint < 10) $display("FAIL rand_beat%0d: got %h expected %h", recv, out_data,
                                      exp_v);
            nprint++;
          end
        end
        recv++;
      end
      stall     = out_valid && !out_ready;
      last_data = out_data;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (recv != NRand || sent != NRand) begin
      n_fail++;
      $display("FAIL rand_count: got sent=%0d recv=%0d expected %0d each", sent, recv, NRand);
    end
    step();
    step();
    step();
    n_checks++;
    if (out_valid !== 1'b0 || q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_drain: got out_valid=%b pending=%0d expected 0/0", out_valid, q.size());
    end
  endtask

  task automatic test_rst_midstream();
    logic [63:0] exp_v;
    exp_v = pack4(100, -200, 300, -400);
    out_ready = 1'b0;
    push_beat(2'd3, pack4(4096, 4096, 4096, 4096));
    push_beat(2'd2, pack4(1, 2, 3, 4));
    push_beat(2'd1, pack4(-5, 6, -7, 8));
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_prefill: out_valid got %b expected 1", out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 64'h0) begin
      n_fail++;
      $display("FAIL rst_async_clear: got v=%b %h expected v=0 0", out_valid, out_data);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_release_in_ready: got %b expected 1", in_ready);
    end
    push_beat(2'd0, exp_v);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_post_lat1: out_valid got %b expected 0", out_valid);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_post_lat2: out_valid got %b expected 0", out_valid);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== exp_v) begin
      n_fail++;
      $display("FAIL rst_post_beat: got v=%b %h expected v=1 %h", out_valid, out_data, exp_v);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_no_stale: out_valid got %b expected 0", out_valid);
    end
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 2'd0;
    in_data   = '0;
    out_ready = 1'b1;
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_silu();
    test_sigmoid_relu();
    test_saturation();
    test_back_to_back();
    test_rst_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
